timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped 32-bit countdown timer on the data bus, directly downstream of the store byte-enable stage.
- Consumes word address, 4-bit byte enables and lane-aligned write data.
- Returns read data for loads and raises an interrupt request toward the CP0/interrupt logic.
- Provides programmable one-shot and auto-reload interrupt generation.

Parameters:
- BASE_ADDR, 32'h0000_7F00: device base address; bits [3:0] must be zero.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  byte address from the store/load stage.
- byteen  input  4  per-lane write enables; 4'b0000 means no write.
- wdata  input  32  lane-aligned write data.
- rdata  output  32  combinational read data for addr.
- irq  output  1  interrupt request, level.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the clock port is named clk and the reset port is named reset.
- Address decode:
  - sel = (addr[31:4]==BASE_ADDR[31:4]) && (addr[3:2]!=2'b11).
  - addr[1:0] is ignored; lanes come from byteen.
- Registers:
  - CTRL @+0: [0] EN, [2:1] MODE, [3] IM; bits [31:4] read 0, writes ignored.
  - PRESET @+4: 32-bit, read/write.
  - COUNT @+8: 32-bit, read-only; writes are dropped.
- Writes:
  - On posedge, when sel && byteen!=0, byte lane i of the target register takes wdata[8i+7:8i] iff byteen[i].
  - The written value is visible on rdata from the next cycle.
- Reads:
  - rdata = selected register, zero-extended.
  - rdata = 0 when !sel or addr[3:2]==3.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0, irq=0.
- FSM (uses register values sampled before this edge's bus write):
  - IDLE: EN -> LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - !EN -> IDLE; COUNT holds.
    - COUNT>1: COUNT<=COUNT-1.
    - COUNT<=1: COUNT<=0, irq_pend<=1 -> INT.
  - INT:
    - MODE==1: -> LOAD and irq_pend<=0 (one-cycle pulse).
    - Otherwise: -> IDLE, CTRL.EN<=0; irq_pend holds.
- irq = irq_pend & CTRL.IM, combinational from registers.
- Clearing irq_pend:
  - Any write to CTRL or PRESET clears irq_pend, except when the FSM sets it on the same edge; set wins.
- Simultaneous events:
  - A bus write to CTRL byte 0 on the same edge as the INT EN-clear: the written EN wins.
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
  - EN cleared in LOAD: LOAD still completes; CNT then exits to IDLE next cycle.
- Timing:
  - CTRL write with EN=1 at edge 0, PRESET=P>=1: LOAD at edge 1, COUNT=P at edge 2, COUNT=0 and irq_pend=1 at edge P+2.
  - P=0 behaves like P=1.
  - MODE 1 period is P+2 cycles.
- MODE 2/3 behave as MODE 0.
- Reset mid-count returns everything to reset values on that edge; no irq is produced.

Decomposition:
- Shared package timer_pkg holds:
  - register offsets (CTRL_OFF, PRESET_OFF, COUNT_OFF);
  - CTRL bit positions;
  - the 2-bit state enum (IDLE, LOAD, CNT, INT);
  - a byte-merge function (old, new, byteen) -> merged word.
- No sub-module; single module with one FSM process and one register-write process.

Test Plan:
- Reset, then read +0/+4/+8 -> rdata 0 each, irq=0; read +C -> 0.
- Write PRESET=5 (byteen 1111), then CTRL=32'h9 (EN=1, MODE=0, IM=1) at edge 0 -> COUNT reads 5 after edge 2 and 1 after edge 6; irq=1 after edge 7; CTRL.EN=0 after edge 8; irq stays 1 until a PRESET write clears it.
- Same setup with CTRL=32'hB (MODE=1) -> irq high for exactly one cycle after edges 7, 14, 21; COUNT reloads to 5 each period.
- Byte-lane write: PRESET=32'h11223344, then write wdata=32'hAABBCCDD with byteen=4'b0110 -> PRESET reads 32'h11BBCC44. Write to +8 -> COUNT unchanged.
- MODE 0 with IM=0 -> irq stays 0 at expiry; then write CTRL IM=1 with EN=0 -> pend cleared by the CTRL write, irq stays 0.
- Clear EN (write CTRL=0) while COUNT=3 -> state IDLE next edge, COUNT holds 3, no irq. Assert reset during CNT -> all registers 0, irq 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL field positions, FSM state encoding and the byte-lane merge helper.
package timer_pkg;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// 32-bit countdown timer on the data bus with one-shot and auto-reload modes
// and a level interrupt gated by CTRL.IM.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [CTRL_W-1:0]   ctrl_base;
  logic [31:0]         preset_q;
  logic [31:0]         count_q, count_d;
  logic                irq_pend_q;
  logic                sel, wr, wr_ctrl, wr_preset;
  logic                pend_set, pend_fsm_clr, en_clr;
  logic [1:0]          widx;
  logic [1:0]          mode;
  logic [31:0]         ctrl_merged;
  logic                unused_bits;

  assign widx      = addr[3:2];
  assign sel       = (addr[31:4] == BASE_ADDR[31:4]) && (widx != 2'b11);
  assign wr        = sel && (byteen != 4'b0000);
  assign wr_ctrl   = wr && (widx == CTRL_OFF);
  assign wr_preset = wr && (widx == PRESET_OFF);
  assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  // Next state computed purely from pre-edge register values
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pend_set     = 1'b0;
    pend_fsm_clr = 1'b0;
    en_clr       = 1'b0;
    unique case (state_q)
      IDLE: if (ctrl_q[CTRL_EN]) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d  = '0;
          pend_set = 1'b1;
          state_d  = INT;
        end
      end
      INT: begin
        if (mode == 2'd1) begin
          state_d      = LOAD;
          pend_fsm_clr = 1'b1;
        end else begin
          state_d = IDLE;
          en_clr  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pend_set)                    irq_pend_q <= 1'b1;
      else if (pend_fsm_clr)           irq_pend_q <= 1'b0;
      else if (wr_ctrl || wr_preset)   irq_pend_q <= 1'b0;
    end
  end

  // A bus write to CTRL byte 0 overrides the FSM's EN clear on the same edge
  always_comb begin
    ctrl_base = ctrl_q;
    if (en_clr) ctrl_base[CTRL_EN] = 1'b0;
    ctrl_merged = byte_merge({28'b0, ctrl_base}, wdata, wr_ctrl ? byteen : 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q <= ctrl_merged[CTRL_W-1:0];
      if (wr_preset) preset_q <= byte_merge(preset_q, wdata, byteen);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (widx)
        CTRL_OFF:   rdata = {28'b0, ctrl_q};
        PRESET_OFF: rdata = preset_q;
        COUNT_OFF:  rdata = count_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = irq_pend_q & ctrl_q[CTRL_IM];

  assign unused_bits = ^{addr[1:0], ctrl_merged[31:CTRL_W]};

endmodule

// File: tb/tb_timer_dev.sv
// Randomized and directed bench for timer_dev against a cycle-level
// behavioural model of the timer's programming rules.
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase 0 waiting for EN, 1 reload pending, 2 counting, 3 expired
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_pend;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .byteen(byteen),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return (a[31:4] == b[31:4]) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (!in_window(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit          en, wr, set, fclr, enclr;
    logic [1:0]  mode;
    int          nphase;
    logic [31:0] ncount;
    logic [3:0]  c;
    if (reset) begin
      m_phase = 0; m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 1'b0;
      return;
    end
    en = m_ctrl[0]; mode = m_ctrl[2:1];
    nphase = m_phase; ncount = m_count; set = 0; fclr = 0; enclr = 0;
    if (m_phase == 0) begin
      if (en) nphase = 1;
    end else if (m_phase == 1) begin
      ncount = m_preset; nphase = 2;
    end else if (m_phase == 2) begin
      if (!en) nphase = 0;
      else if (m_count > 1) ncount = m_count - 1;
      else begin ncount = 0; set = 1; nphase = 3; end
    end else begin
      if (mode == 2'd1) begin nphase = 1; fclr = 1; end
      else begin nphase = 0; enclr = 1; end
    end
    wr = in_window(addr) && (byteen != 4'b0);
    c = m_ctrl;
    if (enclr) c[0] = 1'b0;
    if (wr && addr[3:2] == 2'd0 && byteen[0]) c = wdata[3:0];
    if (wr && addr[3:2] == 2'd1)
      for (int i = 0; i < 4; i++) if (byteen[i]) m_preset[8*i +: 8] = wdata[8*i +: 8];
    if (set) m_pend = 1'b1;
    else if (fclr) m_pend = 1'b0;
    else if (wr && addr[3:2] < 2'd2) m_pend = 1'b0;
    m_ctrl = c; m_count = ncount; m_phase = nphase;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("irq", {31'b0, irq}, {31'b0, m_pend & m_ctrl[3]});
    check("rdata", rdata, model_rdata(addr));
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
    addr = BASE + off; wdata = data; byteen = be;
    step();
    byteen = 4'b0;
  endtask

  task automatic set_rd(input logic [31:0] off);
    addr = BASE + off; byteen = 4'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
    set_rd(off);
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; byteen = 4'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1; addr = BASE; byteen = 4'b0; wdata = '0;
    m_phase = 0; m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 1'b0;
    step(); step();
    reset = 1'b0;

    rd_check("rst_ctrl", 0, 0);
    rd_check("rst_preset", 4, 0);
    rd_check("rst_count", 8, 0);
    rd_check("rst_hole", 12, 0);
    check("rst_irq", {31'b0, irq}, 0);
    bus_write(4, 32'h1234_5678, 4'hF);
    rd_check("offbase", 16, 0);

    // one-shot, P=5
    do_reset();
    bus_write(4, 5, 4'hF);
    bus_write(0, 32'h9, 4'hF);
    set_rd(8);
    step(); step();
    check("m0_cnt5", rdata, 5);
    repeat (4) step();
    check("m0_cnt1", rdata, 1);
    step();
    check("m0_irq", {31'b0, irq}, 1);
    set_rd(0);
    step();
    check("m0_en_clr", rdata, 32'h8);
    repeat (3) step();
    check("m0_irq_hold", {31'b0, irq}, 1);
    bus_write(4, 5, 4'hF);
    check("m0_irq_clr", {31'b0, irq}, 0);

    // auto-reload, P=5, period 7
    do_reset();
    bus_write(4, 5, 4'hF);
    bus_write(0, 32'hB, 4'hF);
    set_rd(8);
    for (int e = 1; e <= 22; e++) begin
      step();
      check("m1_irq", {31'b0, irq}, {31'b0, (e == 7 || e == 14 || e == 21)});
      if (e == 2 || e == 9 || e == 16) check("m1_reload", rdata, 5);
    end

    // byte lanes and read-only COUNT
    do_reset();
    bus_write(4, 32'h1122_3344, 4'hF);
    bus_write(4, 32'hAABB_CCDD, 4'b0110);
    rd_check("lane_merge", 4, 32'h11BB_CC44);
    bus_write(8, 32'hFFFF_FFFF, 4'hF);
    rd_check("count_ro", 8, 0);

    // masked expiry, then CTRL write clears the pending flag
    do_reset();
    bus_write(4, 2, 4'hF);
    bus_write(0, 32'h1, 4'hF);
    for (int e = 1; e <= 6; e++) begin
      step();
      check("im0_irq", {31'b0, irq}, 0);
    end
    bus_write(0, 32'h8, 4'hF);
    check("im0_clr", {31'b0, irq}, 0);
    step();
    check("im0_clr2", {31'b0, irq}, 0);

    // stop at COUNT=3
    do_reset();
    bus_write(4, 10, 4'hF);
    bus_write(0, 32'h9, 4'hF);
    set_rd(8);
    repeat (8) step();
    bus_write(0, 0, 4'hF);
    set_rd(8);
    step();
    check("stop_hold", rdata, 3);
    repeat (3) step();
    check("stop_hold2", rdata, 3);
    check("stop_irq", {31'b0, irq}, 0);

    // reset in the middle of counting
    bus_write(0, 32'h9, 4'hF);
    repeat (4) step();
    do_reset();
    rd_check("mid_rst_ctrl", 0, 0);
    rd_check("mid_rst_preset", 4, 0);
    rd_check("mid_rst_count", 8, 0);
    check("mid_rst_irq", {31'b0, irq}, 0);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      reset = 1'b0;
      if (r < 1) begin
        reset = 1'b1; byteen = 4'b0;
      end else if (r < 70) begin
        addr = BASE + 32'($urandom_range(0, 15)); byteen = 4'b0; wdata = $urandom;
      end else if (r < 82) begin
        addr = BASE + 32'd4 + 32'($urandom_range(0, 3));
        wdata = 32'($urandom_range(0, 9));
        byteen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
      end else if (r < 88) begin
        addr = BASE + 32'($urandom_range(0, 3));
        wdata = $urandom; byteen = 4'($urandom_range(1, 15));
      end else if (r < 94) begin
        addr = BASE + (($urandom_range(0, 1) == 1) ? 32'd8 : 32'd12);
        wdata = $urandom; byteen = 4'($urandom_range(1, 15));
      end else begin
        addr = $urandom; wdata = $urandom; byteen = 4'($urandom_range(0, 15));
      end
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
